// File: rtl/input_debounce_sync.sv
// Synchronises an asynchronous raw input and debounces it into a stable level.
// Define DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module input_debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES) + 1,
    parameter int unsigned GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                raw_in,
    output logic                level_out,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
`else
    output logic                busy
`endif
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || STABLE_CYCLES < 2 || STABLE_CYCLES > 65535 ||
        GLITCH_W < 1) begin : g_param_check
        $error("input_debounce_sync: parameter out of legal range");
    end

    // Encoding puts level_out in bit 1 and busy in bit 0 so outputs come straight from flops.
    typedef enum logic [1:0] {
        SLow      = 2'b00,
        SQualHigh = 2'b01,
        SHigh     = 2'b10,
        SQualLow  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   glitch;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= SLow;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        glitch  = 1'b0;
        if (!enable) begin
            // Abort without counting a glitch; stable states simply hold.
            cnt_d = '0;
            if (state_q == SQualHigh) state_d = SLow;
            if (state_q == SQualLow)  state_d = SHigh;
        end else begin
            unique case (state_q)
                SLow: begin
                    if (s) begin
                        state_d = SQualHigh;
                        cnt_d   = CntOne;
                    end
                end
                SQualHigh: begin
                    if (!s) begin
                        state_d = SLow;
                        cnt_d   = '0;
                        glitch  = 1'b1;
                    end else if (cnt_q == CntLast) begin
                        state_d = SHigh;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                SHigh: begin
                    if (!s) begin
                        state_d = SQualLow;
                        cnt_d   = CntOne;
                    end
                end
                SQualLow: begin
                    if (s) begin
                        state_d = SHigh;
                        cnt_d   = '0;
                        glitch  = 1'b1;
                    end else if (cnt_q == CntLast) begin
                        state_d = SLow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            endcase
        end
    end

    assign level_out = state_q[1];
    assign busy      = state_q[0];

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;

    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (glitch && glitch_cnt_q != '1) glitch_cnt_d = glitch_cnt_q + GLITCH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) glitch_cnt_q <= '0;
        else        glitch_cnt_q <= glitch_cnt_d;
    end

    assign glitch_cnt = glitch_cnt_q;
`else
    logic unused_glitch;
    assign unused_glitch = glitch;
`endif

endmodule
